led_pattern_seq: RTL and testbench
==================================

# led_pattern_seq

LED pattern sequencer placed directly downstream of the board's free-running prescaler counter. Consumes a one-cycle `step` strobe (one pulse per prescaler wrap) and drives a bank of LEDs with one of four selectable patterns: blink, chase, bounce, or PWM breathe. It replaces driving a single LED straight from a counter MSB, and all pattern timing derives from `step`.

## Interface
- `N_LEDS`, default 4: number of LED outputs; legal range 2..16.
- `PWM_W`, default 8: PWM counter and duty width; legal range 2..12.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `step` input 1: one-cycle advance strobe from the prescaler; pulse width must be 1 cycle.
- `mode` input 2: pattern select; 0 blink, 1 chase, 2 bounce, 3 breathe; sampled every cycle.
- `led` output N_LEDS: LED drive, registered, active-high.

## Operation
- Registered state:
  - `mode_q`
  - `blink_on`
  - `pos`, width clog2(N_LEDS)
  - `dir` (0 = up)
  - `duty`, PWM_W bits
  - `duty_dir`
  - `pwm_cnt`, PWM_W bits
- Reset values: all of the above 0; `led` = 0.
- Mode change: if `mode != mode_q`, load `mode_q <= mode` and restore `blink_on`, `pos`, `dir`, `duty` and `duty_dir` to their reset values. A `step` in that same cycle is ignored. `pwm_cnt` is not reset.
- Blink, mode 0: each `step` toggles `blink_on`; `led` = all bits equal to `blink_on`.
- Chase, mode 1: each `step` sets `pos <= (pos == N_LEDS-1) ? 0 : pos+1`; `led` = one-hot at `pos`.
- Bounce, mode 2: two-state direction FSM, UP and DOWN.
  - In UP, `step` increments `pos`. If `pos == N_LEDS-2` before the step, the FSM goes to DOWN.
  - In DOWN, `step` decrements `pos`. If `pos == 1` before the step, the FSM goes to UP.
  - Resulting sequence: 0,1,…,N-1,N-2,…,1,0,1… with no dwell at the ends.
  - `led` = one-hot at `pos`.
- Breathe, mode 3:
  - Each `step` moves `duty` by ±1, bouncing between 0 and 2^PWM_W−1 with no dwell. At max while rising it goes to max−1 and falls; at 0 while falling it goes to 1 and rises.
  - `pwm_cnt` increments every cycle and wraps modulo 2^PWM_W in all modes.
  - `led` = all bits equal to `(pwm_cnt < duty)`, an unsigned compare. `duty` = 0 gives constant off; max duty gives on for 2^PWM_W−1 of every 2^PWM_W cycles.
- `step` asserted during `rst` is ignored.
- `mode` is treated as synchronous to `clk`; the upstream stage is responsible for synchronizing it.

## Timing
- `led` is registered and is computed from the state registers after they update.
  - A `step` at edge k updates state at edge k; the new pattern appears on `led` after edge k+1, i.e. 1-cycle latency from state to LED.
  - Breathe compare uses the current `pwm_cnt` and `duty` and is registered, so `led` lags the compare by 1 cycle.
- Mode change at edge k: the new `mode_q` and reset pattern state take effect at edge k. `led` shows the new mode's initial pattern after edge k+1:
  - blink: all 0
  - chase/bounce: 0…01
  - breathe: 0
- Reset mid-operation: at the first edge with `rst` = 1, all registers go to reset values and `led` = 0 from that edge. Operation resumes at the first edge after `rst` deasserts.
- Back-to-back `step` on consecutive cycles is not legal input; the behaviour is defined anyway as one advance per asserted cycle.

## Structure
- Shared package `led_pkg`:
  - mode constants `MODE_BLINK`=2'd0, `MODE_CHASE`=2'd1, `MODE_BOUNCE`=2'd2, `MODE_BREATHE`=2'd3
  - a `mode_t` 2-bit typedef
- Sub-module `led_pwm`: parameter `PWM_W`; ports `clk`, `rst`, `duty`, `pwm_out`. It holds `pwm_cnt` and the compare, with `pwm_out` registered.
- Top level holds the mode register, pattern state, bounce FSM and output mux.
- Target size is 120–250 lines of RTL total.

## Test plan
All scenarios use N_LEDS=4 and PWM_W=4.
1. Reset, then mode=0, 3 steps 10 cycles apart → `led` goes 0000 → 1111 → 0000 → 1111, each change 1 cycle after the state update.
2. mode=1, 5 steps → `led` sequence 0001, 0010, 0100, 1000, 0001, 0010, showing wrap at N−1.
3. mode=2, 8 steps → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100, with no repeat at either end.
4. mode=3:
   - After 0 steps → `led` constantly 0000 for 32 cycles.
   - After 15 steps (`duty`=15) → `led` high for 15 of every 16 cycles.
   - A 16th step → `duty`=14, falling.
5. mode=2 at `pos`=3 and DOWN, then switch mode to 1 in a cycle that also has `step` → step ignored; `led`=0001 one cycle later; next step gives 0010.
6. mode=1 at `pos`=2, assert `rst` for 1 cycle with `step` high → `led`=0000 at that edge; after release, `led` returns 0001, then steps continue from `pos`=0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared mode encoding for the LED pattern sequencer.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BLINK   = 2'd0;
  localparam mode_t MODE_CHASE   = 2'd1;
  localparam mode_t MODE_BOUNCE  = 2'd2;
  localparam mode_t MODE_BREATHE = 2'd3;

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter with a registered duty compare.
module led_pwm #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_out
);

  logic [PWM_W-1:0] pwm_cnt;

  // The counter runs in every mode so the breathe phase never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: blink, chase, bounce and PWM breathe, advanced by a step strobe.
//   state | meaning
//   UP    | bounce position climbing toward N_LEDS-1
//   DOWN  | bounce position falling toward 0
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int PWM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_TURN = POS_W'(N_LEDS - 2);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  mode_t             mode_q;
  logic              blink_on;
  logic [POS_W-1:0]  pos;
  dir_t              dir;
  logic [PWM_W-1:0]  duty;
  logic              duty_dir;
  logic              pwm_out;
  logic [N_LEDS-1:0] pattern;

  led_pwm #(.PWM_W(PWM_W)) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_BLINK:   pattern = {N_LEDS{blink_on}};
      MODE_CHASE,
      MODE_BOUNCE:  pattern[pos] = 1'b1;
      MODE_BREATHE: pattern = {N_LEDS{pwm_out}};
      default:      pattern = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_BLINK;
      blink_on <= 1'b0;
      pos      <= '0;
      dir      <= UP;
      duty     <= '0;
      duty_dir <= 1'b0;
      led      <= '0;
    end else begin
      led <= pattern;
      if (mode != mode_q) begin
        // A step coinciding with a mode change is dropped.
        mode_q   <= mode;
        blink_on <= 1'b0;
        pos      <= '0;
        dir      <= UP;
        duty     <= '0;
        duty_dir <= 1'b0;
      end else if (step) begin
        case (mode_q)
          MODE_BLINK: blink_on <= ~blink_on;
          MODE_CHASE: pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
          MODE_BOUNCE: begin
            if (dir == UP) begin
              pos <= pos + 1'b1;
              if (pos == POS_TURN) dir <= DOWN;
            end else begin
              pos <= pos - 1'b1;
              if (pos == POS_W'(1)) dir <= UP;
            end
          end
          MODE_BREATHE: begin
            if (!duty_dir) begin
              if (duty == DUTY_MAX) begin
                duty     <= DUTY_MAX - 1'b1;
                duty_dir <= 1'b1;
              end else begin
                duty <= duty + 1'b1;
              end
            end else begin
              if (duty == '0) begin
                duty     <= PWM_W'(1);
                duty_dir <= 1'b0;
              end else begin
                duty <= duty - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: vector table, hand sequences and a random run against a step-count model.
module tb_led_pattern_seq;

  localparam int N = 4;
  localparam int W = 4;
  localparam int DMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         step = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] led;

  int vectors = 0;
  int errors  = 0;

  led_pattern_seq #(.N_LEDS(N), .PWM_W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .mode (mode),
    .led  (led)
  );

  always #5 clk = ~clk;

  // Model: pattern is a function of steps taken since the last mode change.
  int           m_mode = 0;
  int           m_n    = 0;
  int           m_cnt  = 0;
  logic         m_pwm  = 1'b0;
  logic [N-1:0] m_led  = '0;

  function automatic int tri_wave(input int n, input int top);
    int p, r;
    p = 2 * top;
    r = n % p;
    return (r <= top) ? r : p - r;
  endfunction

  function automatic logic [N-1:0] model_pattern(input int md, input int n, input logic pw);
    logic [N-1:0] one;
    one = 1;
    case (md)
      0:       return (n % 2) ? {N{1'b1}} : '0;
      1:       return one << (n % N);
      2:       return one << tri_wave(n, N - 1);
      default: return {N{pw}};
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic [1:0] m);
    logic [N-1:0] nl;
    logic         np;
    int           d;
    if (r) begin
      m_mode = 0; m_n = 0; m_cnt = 0; m_pwm = 1'b0; m_led = '0;
    end else begin
      d  = (m_mode == 3) ? tri_wave(m_n, DMAX) : 0;
      nl = model_pattern(m_mode, m_n, m_pwm);
      np = (m_cnt < d);
      m_cnt = (m_cnt + 1) % (DMAX + 1);
      if (int'(m) != m_mode) begin
        m_mode = int'(m);
        m_n    = 0;
      end else if (s) begin
        m_n++;
      end
      m_led = nl;
      m_pwm = np;
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic [1:0] m);
    rst = r; step = s; mode = m;
    @(posedge clk);
    model_edge(r, s, m);
    #1;
  endtask

  task automatic check(input string name, input logic [N-1:0] exp);
    vectors++;
    if (led !== exp) begin
      errors++;
      $display("FAIL %s: led=%b expected=%b at %0t", name, led, exp, $time);
    end
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic [1:0] m;
    logic [3:0] l;
  } vec_t;

  vec_t tbl[$];
  int   ones;

  initial begin
    // Reset, chase wrap, bounce turnarounds, reset with step high.
    tbl.push_back('{1'b1, 1'b0, 2'd0, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b0001});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 4'b0001});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b0010});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 4'b0010});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b0100});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 4'b0100});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b1000});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 4'b1000});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b0001});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b0001});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0001});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b0001});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0010});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b0010});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0100});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b0100});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b1000});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b1000});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0100});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b0100});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0010});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b0010});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0001});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b0001});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0010});
    tbl.push_back('{1'b1, 1'b1, 2'd1, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b0001});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 4'b0001});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b0010});

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].s, tbl[i].m);
      check($sformatf("table[%0d]", i), tbl[i].l);
    end

    // Blink with steps 10 cycles apart.
    tick(1'b1, 1'b0, 2'd0);
    tick(1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 2'd0);
      check("blink_state_edge", (k % 2) ? 4'b1111 : 4'b0000);
      for (int c = 0; c < 9; c++) begin
        tick(1'b0, 1'b0, 2'd0);
        check("blink_hold", (k % 2) ? 4'b0000 : 4'b1111);
      end
    end

    // Breathe: zero duty stays dark, full duty lit 15/16, then one step down.
    tick(1'b1, 1'b0, 2'd0);
    tick(1'b0, 1'b0, 2'd3);
    for (int c = 0; c < 32; c++) begin
      tick(1'b0, 1'b0, 2'd3);
      check("breathe_zero", 4'b0000);
    end
    for (int k = 0; k < 15; k++) begin
      tick(1'b0, 1'b1, 2'd3);
      tick(1'b0, 1'b0, 2'd3);
    end
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 2'd3);
    ones = 0;
    for (int c = 0; c < 16; c++) begin
      tick(1'b0, 1'b0, 2'd3);
      if (led !== 4'b0000 && led !== 4'b1111) begin
        vectors++; errors++;
        $display("FAIL breathe_uniform: led=%b expected=0000 or 1111", led);
      end
      if (led == 4'b1111) ones++;
    end
    vectors++;
    if (ones != 15) begin
      errors++;
      $display("FAIL breathe_max_duty: on_cycles=%0d expected=15", ones);
    end
    tick(1'b0, 1'b1, 2'd3);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 2'd3);
    ones = 0;
    for (int c = 0; c < 16; c++) begin
      tick(1'b0, 1'b0, 2'd3);
      if (led == 4'b1111) ones++;
    end
    vectors++;
    if (ones != 14) begin
      errors++;
      $display("FAIL breathe_falling: on_cycles=%0d expected=14", ones);
    end

    // Bounce at pos 3 heading down, then switch to chase with a step in the same cycle.
    tick(1'b0, 1'b0, 2'd2);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 2'd2);
      tick(1'b0, 1'b0, 2'd2);
    end
    check("bounce_at_top", 4'b1000);
    tick(1'b0, 1'b1, 2'd1);
    check("modechg_old_pattern", 4'b1000);
    tick(1'b0, 1'b0, 2'd1);
    check("modechg_step_ignored", 4'b0001);
    tick(1'b0, 1'b1, 2'd1);
    tick(1'b0, 1'b0, 2'd1);
    check("modechg_next_step", 4'b0010);

    // Random run against the model.
    tick(1'b1, 1'b0, 2'd0);
    for (int c = 0; c < 3000; c++) begin
      logic       r, s;
      logic [1:0] m;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(0, 3)) : mode;
      tick(r, s, m);
      check("random", m_led);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
